// File: rtl/addsub_serial_pkg.sv
// Shared constants for the bit-serial add/subtract unit: state codes,
// mode encodings and the sizing rule for the bit counter.
package addsub_serial_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Counter has to index bits 0..width-1; keep at least one bit for width 2.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Request/response bundle between the operand source, the add/sub unit
// and the result consumer.
interface addsub_serial_if #(
    parameter int WIDTH = 4
);
    logic             req_valid;
    logic             req_ready;
    logic             mode;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] result;
    logic             co;
    logic             overflow;

    // Side that issues operands and consumes results
    modport master (
        output req_valid, mode, operand_a, operand_b, rsp_ready,
        input  req_ready, rsp_valid, result, co, overflow
    );

    // The arithmetic unit itself
    modport slave (
        input  req_valid, mode, operand_a, operand_b, rsp_ready,
        output req_ready, rsp_valid, result, co, overflow
    );

endinterface

// File: rtl/addsub_serial_fa_bit.sv
// One-bit full adder used as the single serial datapath cell.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/addsub_serial.sv
// Bit-serial two's-complement adder/subtractor. Subtraction is a + ~b + 1:
// b is inverted at accept time and the initial carry is the mode bit.
module addsub_serial
    import addsub_serial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    addsub_serial_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] result_q;
    logic             co_q;
    logic             ovf_q;
    logic             sum_bit;
    logic             carry_next;

    fa_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (sum_bit),
        .cout (carry_next)
    );

    // Sequencer: accept operands, step one bit per clock, hold the result until taken
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            co_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        a_sh  <= bus.operand_a;
                        b_sh  <= bus.operand_b ^ {WIDTH{bus.mode}};
                        carry <= bus.mode;
                        cnt   <= '0;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    acc   <= {sum_bit, acc[WIDTH-1:1]};
                    carry <= carry_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        result_q <= {sum_bit, acc[WIDTH-1:1]};
                        co_q     <= carry_next;
                        ovf_q    <= carry ^ carry_next;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_DONE);
    assign bus.result    = result_q;
    assign bus.co        = co_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial (WIDTH=4): an arithmetic reference
// model tracked cycle by cycle, plus directed cases with literal expectations.
module tb_addsub_serial;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    addsub_serial_if #(.WIDTH(WIDTH)) bus ();

    addsub_serial #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int         m_wait = 0;
    logic       m_valid = 1'b0;
    logic [3:0] m_result = 4'd0;
    logic       m_co = 1'b0;
    logic       m_ovf = 1'b0;
    logic [3:0] p_result = 4'd0;
    logic       p_co = 1'b0;
    logic       p_ovf = 1'b0;

    // Pure arithmetic reference: returns {overflow, co, result}
    function automatic logic [5:0] ref_op(input logic [3:0] a, input logic [3:0] b, input logic m);
        int sa;
        int sb;
        int tr;
        int u;
        logic [3:0] binv;
        logic [3:0] r;
        logic c;
        logic o;
        sa = (a > 4'd7) ? int'(a) - 16 : int'(a);
        sb = (b > 4'd7) ? int'(b) - 16 : int'(b);
        tr = m ? sa - sb : sa + sb;
        binv = m ? ~b : b;
        u = int'(a) + int'(binv) + int'(m);
        r = 4'(tr);
        c = (u >= 16);
        o = (tr < -8) || (tr > 7);
        return {o, c, r};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model advances on each rising edge using the stable, bench-driven inputs
    always @(posedge clk) begin
        if (!reset_n) begin
            m_wait   <= 0;
            m_valid  <= 1'b0;
            m_result <= 4'd0;
            m_co     <= 1'b0;
            m_ovf    <= 1'b0;
        end else if (m_wait == 0 && !m_valid && bus.req_valid) begin
            m_wait <= WIDTH;
            {p_ovf, p_co, p_result} <= ref_op(bus.operand_a, bus.operand_b, bus.mode);
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_valid <= 1'b1;
                {m_ovf, m_co, m_result} <= {p_ovf, p_co, p_result};
            end
        end else if (m_valid && bus.rsp_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Compare every cycle on the falling edge, away from DUT updates
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("req_ready", int'(bus.req_ready), int'(m_wait == 0 && !m_valid));
            checkOutput("rsp_valid", int'(bus.rsp_valid), int'(m_valid));
            checkOutput("result",    int'(bus.result),    int'(m_result));
            checkOutput("co",        int'(bus.co),        int'(m_co));
            checkOutput("overflow",  int'(bus.overflow),  int'(m_ovf));
        end
    end

    // Present a request and return at the falling edge after it is accepted
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic m);
        int t;
        bus.req_valid = 1'b1;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.mode      = m;
        t = 0;
        while (!bus.req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) checkOutput("accept_timeout", 0, 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.operand_a = 4'($urandom);
        bus.operand_b = 4'($urandom);
        bus.mode      = 1'($urandom);
    endtask

    // Wait for the response, stall for 'hold' cycles, then take it
    task automatic collectResponse(input int hold, output logic [3:0] r, output logic c,
                                   output logic o, output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.rsp_valid) checkOutput("response_timeout", 0, 1);
        r = bus.result;
        c = bus.co;
        o = bus.overflow;
        repeat (hold) @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    // Directed case with literal expected values
    task automatic directedCase(input string name, input logic [3:0] a, input logic [3:0] b,
                                input logic m, input logic [3:0] er, input logic ec, input logic eo);
        logic [3:0] r;
        logic c;
        logic o;
        int lat;
        applyStimulus(a, b, m);
        collectResponse(1, r, c, o, lat);
        checkOutput({name, "_latency"}, lat, 4);
        checkOutput({name, "_result"}, int'(r), int'(er));
        checkOutput({name, "_co"}, int'(c), int'(ec));
        checkOutput({name, "_overflow"}, int'(o), int'(eo));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] r;
        logic c;
        logic o;
        int lat;

        bus.req_valid = 1'b0;
        bus.mode      = 1'b0;
        bus.operand_a = 4'd0;
        bus.operand_b = 4'd0;
        bus.rsp_ready = 1'b0;

        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        checkOutput("reset_req_ready", int'(bus.req_ready), 1);
        checkOutput("reset_rsp_valid", int'(bus.rsp_valid), 0);
        checkOutput("reset_result",    int'(bus.result),    0);
        checkOutput("reset_co",        int'(bus.co),        0);
        checkOutput("reset_overflow",  int'(bus.overflow),  0);

        directedCase("sub_3_5",   4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0, 1'b0);
        directedCase("add_7_1",   4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
        directedCase("sub_m8_1",  4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1);
        directedCase("add_5_m3",  4'b0101, 4'b1101, 1'b0, 4'b0010, 1'b1, 1'b0);

        // Backpressure: 6-2 held in DONE while a new request (2+3) waits
        applyStimulus(4'd6, 4'd2, 1'b1);
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("bp_latency", lat, 4);
        bus.req_valid = 1'b1;
        bus.operand_a = 4'd2;
        bus.operand_b = 4'd3;
        bus.mode      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_rsp_valid_held", int'(bus.rsp_valid), 1);
            checkOutput("bp_req_ready_low",  int'(bus.req_ready), 0);
            checkOutput("bp_result_held",    int'(bus.result),    4);
            checkOutput("bp_co_held",        int'(bus.co),        1);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checkOutput("bp_release_req_ready", int'(bus.req_ready), 1);
        checkOutput("bp_release_rsp_valid", int'(bus.rsp_valid), 0);
        applyStimulus(4'd2, 4'd3, 1'b0);
        checkOutput("bp_accepted_next_edge", int'(bus.req_ready), 0);
        collectResponse(0, r, c, o, lat);
        checkOutput("bp2_result", int'(r), 5);
        checkOutput("bp2_co", int'(c), 0);
        checkOutput("bp2_overflow", int'(o), 0);

        // Reset asserted on the second CALC edge aborts the operation
        applyStimulus(4'd1, 4'd2, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checkOutput("midrst_req_ready", int'(bus.req_ready), 1);
        checkOutput("midrst_rsp_valid", int'(bus.rsp_valid), 0);
        checkOutput("midrst_result",    int'(bus.result),    0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("midrst_no_response", int'(bus.rsp_valid), 0);
        end

        // All operand pairs in both modes with random consumer stalls
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    applyStimulus(4'(a), 4'(b), 1'(m));
                    collectResponse(int'($urandom_range(0, 2)), r, c, o, lat);
                    checkOutput("exh_latency", lat, 4);
                end
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
